// File: rtl/i_cache_fill_ctrl.sv
// i_cache_fill_ctrl
//   Miss/fill sequencer for the fully associative instruction cache.
//   Takes a miss from the lookup stage and issues a single line fill towards
//   i_mem. It captures the matching response and writes the line into the
//   victim way through the shared tag/valid/data write port.
//   The victim is the first invalid way, otherwise the pseudo-LRU choice.
//   This block owns the valid vector and the PLRU tree, and performs
//   invalidate-all on flush.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   miss_valid/address  miss from lookup (ignored while busy)
//   hit_valid/hit_way   lookup hit, touches PLRU in any state
//   flush               invalidate all lines
//   fill_req_*          valid/ready request to i_mem, line-aligned address
//   fill_rsp_*          returned line; only a tag match is accepted
//   wr_en/way/tag/data  one-cycle array write strobe and payload
//   valid_vec           per-way valid bits
//   busy                fill in progress
//
// Optional: define I_CACHE_FILL_PERF_EN to add the saturating counters
//   perf_miss_cnt and perf_fill_cycles.
module i_cache_fill_ctrl #(
  parameter int unsigned WAYS_NUM          = 16,
  parameter int unsigned CL_WIDTH          = 128,
  parameter int unsigned TAG_ADDRESS_WIDTH = 28,
  parameter int unsigned PLRU_BITS         = WAYS_NUM - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  input  logic [31:0]                   miss_address,
  input  logic                          hit_valid,
  input  logic [$clog2(WAYS_NUM)-1:0]   hit_way,
  input  logic                          flush,
  output logic                          fill_req_valid,
  input  logic                          fill_req_ready,
  output logic [31:0]                   fill_req_address,
  input  logic                          fill_rsp_valid,
  input  logic [31:0]                   fill_rsp_address,
  input  logic [CL_WIDTH-1:0]           fill_rsp_data,
  output logic                          wr_en,
  output logic [$clog2(WAYS_NUM)-1:0]   wr_way,
  output logic [TAG_ADDRESS_WIDTH-1:0]  wr_tag,
  output logic [CL_WIDTH-1:0]           wr_data,
  output logic [WAYS_NUM-1:0]           valid_vec,
  output logic                          busy
`ifdef I_CACHE_FILL_PERF_EN
  ,
  output logic [31:0]                   perf_miss_cnt,
  output logic [31:0]                   perf_fill_cycles
`endif
);

  localparam int unsigned WAY_W  = $clog2(WAYS_NUM);
  localparam int unsigned NODE_W = $clog2(PLRU_BITS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, WRITE} state_t;

  state_t                         state_q, state_d;
  logic [TAG_ADDRESS_WIDTH-1:0]   tag_q, tag_d;
  logic [WAY_W-1:0]               victim_q, victim_d;
  logic [CL_WIDTH-1:0]            line_q, line_d;
  logic                           drop_q, drop_d;
  logic [WAYS_NUM-1:0]            valid_q, valid_d;
  logic [PLRU_BITS-1:0]           plru_q, plru_d;
  logic [WAY_W-1:0]               victim_sel;
  logic                           free_found;
  logic                           commit;
  logic                           unused_addr_bits;

  assign unused_addr_bits = ^{miss_address[3:0], fill_rsp_address[3:0]};

  // Walk from the root: a 0 bit selects the lower half, a 1 the upper half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_BITS-1:0] t);
    logic [NODE_W-1:0] node;
    logic [WAY_W-1:0]  r;
    node = '0;
    r    = '0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      r    = (r << 1) | WAY_W'(t[node]);
      node = NODE_W'(2 * int'(node) + 1 + int'(t[node]));
    end
    return r;
  endfunction

  // Every node on the path of w is set to point away from w.
  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] t,
                                                       input logic [WAY_W-1:0]     w);
    logic [NODE_W-1:0]    node;
    logic [WAY_W-1:0]     ws;
    logic                 b;
    logic [PLRU_BITS-1:0] r;
    r    = t;
    ws   = w;
    node = '0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      b       = ws[WAY_W-1];
      ws      = ws << 1;
      r[node] = ~b;
      node    = NODE_W'(2 * int'(node) + 1 + int'(b));
    end
    return r;
  endfunction

  always_comb begin
    victim_sel = plru_victim(plru_q);
    free_found = 1'b0;
    for (int unsigned i = 0; i < WAYS_NUM; i++) begin
      if (!free_found && !valid_q[i]) begin
        victim_sel = WAY_W'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    victim_d       = victim_q;
    line_d         = line_q;
    drop_d         = drop_q;
    valid_d        = valid_q;
    plru_d         = plru_q;
    commit         = 1'b0;
    fill_req_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_valid && !flush) begin
          state_d  = REQ;
          tag_d    = miss_address[31:4];
          victim_d = victim_sel;
          drop_d   = 1'b0;
        end
      end
      REQ: begin
        fill_req_valid = 1'b1;
        if (fill_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (fill_rsp_valid && fill_rsp_address[31:4] == tag_q) begin
          line_d  = fill_rsp_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        commit  = !drop_q && !flush;
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Hit touch first, then fill touch, so the fill owns shared nodes;
    // flush overrides both.
    if (hit_valid) plru_d = plru_touch(plru_d, hit_way);
    if (commit) begin
      plru_d            = plru_touch(plru_d, victim_q);
      valid_d[victim_q] = 1'b1;
    end
    if (flush) begin
      plru_d  = '0;
      valid_d = '0;
      // An in-flight fill still finishes its handshake but must not write.
      if (state_q == REQ || state_q == WAIT_RSP) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      victim_q <= '0;
      line_q   <= '0;
      drop_q   <= 1'b0;
      valid_q  <= '0;
      plru_q   <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
      line_q   <= line_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      plru_q   <= plru_d;
    end
  end

  assign fill_req_address = {tag_q, 4'b0000};
  assign wr_en            = commit;
  assign wr_way           = victim_q;
  assign wr_tag           = tag_q;
  assign wr_data          = line_q;
  assign valid_vec        = valid_q;
  assign busy             = (state_q != IDLE);

`ifdef I_CACHE_FILL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_miss_cnt    <= '0;
      perf_fill_cycles <= '0;
    end else if (flush) begin
      perf_miss_cnt    <= '0;
      perf_fill_cycles <= '0;
    end else begin
      if (state_q == IDLE && state_d == REQ && perf_miss_cnt != '1)
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (busy && perf_fill_cycles != '1)
        perf_fill_cycles <= perf_fill_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i_cache_fill_ctrl.sv
module tb_i_cache_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic [31:0]  miss_address;
  logic         hit_valid;
  logic [3:0]   hit_way;
  logic         flush;
  logic         fill_req_valid;
  logic         fill_req_ready;
  logic [31:0]  fill_req_address;
  logic         fill_rsp_valid;
  logic [31:0]  fill_rsp_address;
  logic [127:0] fill_rsp_data;
  logic         wr_en;
  logic [3:0]   wr_way;
  logic [27:0]  wr_tag;
  logic [127:0] wr_data;
  logic [15:0]  valid_vec;
  logic         busy;
`ifdef I_CACHE_FILL_PERF_EN
  logic [31:0]  perf_miss_cnt;
  logic [31:0]  perf_fill_cycles;
`endif

  i_cache_fill_ctrl #(
    .WAYS_NUM(16), .CL_WIDTH(128), .TAG_ADDRESS_WIDTH(28), .PLRU_BITS(15)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_address(miss_address),
    .hit_valid(hit_valid), .hit_way(hit_way), .flush(flush),
    .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
    .fill_req_address(fill_req_address),
    .fill_rsp_valid(fill_rsp_valid), .fill_rsp_address(fill_rsp_address),
    .fill_rsp_data(fill_rsp_data),
    .wr_en(wr_en), .wr_way(wr_way), .wr_tag(wr_tag), .wr_data(wr_data),
    .valid_vec(valid_vec), .busy(busy)
`ifdef I_CACHE_FILL_PERF_EN
    , .perf_miss_cnt(perf_miss_cnt), .perf_fill_cycles(perf_fill_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [3:0]   way;
    logic [27:0]  tag;
    logic [127:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) obs_q.push_back({cyc, wr_way, wr_tag, wr_data});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    miss_valid = 1'b0; miss_address = '0; hit_valid = 1'b0; hit_way = '0;
    flush = 1'b0; fill_req_ready = 1'b0;
    fill_rsp_valid = 1'b0; fill_rsp_address = '0; fill_rsp_data = '0;
    step(); step();
    rst = 1'b0;
    step();
    exp_q.delete();
    obs_q.delete();
  endtask

  // Starts in an IDLE cycle and ends in the IDLE cycle after the write.
  task automatic do_fill(input logic [31:0] addr, input logic [127:0] data,
                         input int nwait, input logic [3:0] way, input bit expect_wr);
    wr_t e;
    miss_valid = 1'b1; miss_address = addr;
    step();
    miss_valid = 1'b0;
    repeat (nwait) step();
    fill_req_ready = 1'b1;
    step();
    fill_req_ready = 1'b0;
    fill_rsp_valid = 1'b1; fill_rsp_address = {addr[31:4], 4'h0}; fill_rsp_data = data;
    if (expect_wr) begin
      e.cyc = 32'(cyc + 1); e.way = way; e.tag = addr[31:4]; e.data = data;
      exp_q.push_back(e);
    end
    step();
    fill_rsp_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests++; if (fill_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b want 0", fill_req_valid); end
    tests++; if (fill_req_address !== 32'h0) begin fails++; $display("FAIL rst_req_addr: got %h want 0", fill_req_address); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    tests++; if ({wr_way, wr_tag, wr_data} !== '0) begin fails++; $display("FAIL rst_wr_bus: got way %h tag %h data %h want 0", wr_way, wr_tag, wr_data); end
    tests++; if (valid_vec !== 16'h0) begin fails++; $display("FAIL rst_valid_vec: got %h want 0000", valid_vec); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    do_reset();
  endtask

  task automatic test_cold_miss();
    wr_t e, o;
    logic [127:0] d;
    int unsigned t0;
    do_reset();
    d = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    t0 = cyc;
    miss_valid = 1'b1; miss_address = 32'h0000_1004;
    step(); // T+1
    miss_valid = 1'b0;
    tests++; if (fill_req_valid !== 1'b1) begin fails++; $display("FAIL cold_req_valid: got %b want 1", fill_req_valid); end
    tests++; if (fill_req_address !== 32'h0000_1000) begin fails++; $display("FAIL cold_req_addr: got %h want 00001000", fill_req_address); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL cold_busy: got %b want 1", busy); end
    step(); // T+2
    fill_req_ready = 1'b1;
    step(); // T+3
    fill_req_ready = 1'b0;
    tests++; if (fill_req_valid !== 1'b0) begin fails++; $display("FAIL cold_req_drop: got %b want 0", fill_req_valid); end
    step(); // T+4
    step(); // T+5
    fill_rsp_valid = 1'b1; fill_rsp_address = 32'h0000_1000; fill_rsp_data = d;
    e.cyc = 32'(t0 + 6); e.way = 4'd0; e.tag = 28'h0000100; e.data = d;
    exp_q.push_back(e);
    step(); // T+6
    fill_rsp_valid = 1'b0;
    tests++; if (wr_en !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL cold_write: got wr_en %b busy %b want 1 1", wr_en, busy); end
    step(); // T+7
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cold_busy_end: got %b want 0", busy); end
    tests++; if (valid_vec !== 16'h0001) begin fails++; $display("FAIL cold_valid_vec: got %h want 0001", valid_vec); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL cold_sb: no write, want way %0d tag %h cyc %0d", e.way, e.tag, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL cold_sb: got way %0d tag %h cyc %0d data %h, want way %0d tag %h cyc %0d data %h", o.way, o.tag, o.cyc, o.data, e.way, e.tag, e.cyc, e.data); end
      end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL cold_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_fill_all_ways();
    wr_t e, o;
    do_reset();
    for (int i = 0; i < 16; i++)
      do_fill(32'h0001_0000 + 32'(i * 16), {$urandom, $urandom, $urandom, $urandom}, i % 3, 4'(i), 1'b1);
    tests++; if (valid_vec !== 16'hFFFF) begin fails++; $display("FAIL all_valid_vec: got %h want ffff", valid_vec); end
    do_fill(32'h0002_0000, {$urandom, $urandom, $urandom, $urandom}, 0, 4'd0, 1'b1);
    hit_valid = 1'b1; hit_way = 4'd0;
    step();
    hit_valid = 1'b0;
    do_fill(32'h0003_0000, {$urandom, $urandom, $urandom, $urandom}, 0, 4'd8, 1'b1);
    hit_valid = 1'b1; hit_way = 4'd4;
    step();
    hit_valid = 1'b0;
    do_fill(32'h0004_0000, {$urandom, $urandom, $urandom, $urandom}, 1, 4'd12, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL plru_sb: no write, want way %0d tag %h cyc %0d", e.way, e.tag, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL plru_sb: got way %0d tag %h cyc %0d data %h, want way %0d tag %h cyc %0d data %h", o.way, o.tag, o.cyc, o.data, e.way, e.tag, e.cyc, e.data); end
      end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL plru_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_ready_stall();
    wr_t e, o;
    logic [127:0] d;
    do_reset();
    d = 128'hA5A5_0000_1111_2222_3333_4444_5555_5A5A;
    miss_valid = 1'b1; miss_address = 32'h0000_100C;
    step();
    miss_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (fill_req_valid !== 1'b1 || fill_req_address !== 32'h0000_1000 || busy !== 1'b1) begin
        fails++; $display("FAIL stall_hold%0d: got valid %b addr %h busy %b want 1 00001000 1", k, fill_req_valid, fill_req_address, busy);
      end
      if (k < 5) step();
    end
    fill_req_ready = 1'b1;
    step();
    fill_req_ready = 1'b0;
    tests++; if (fill_req_valid !== 1'b0) begin fails++; $display("FAIL stall_req_drop: got %b want 0", fill_req_valid); end
    fill_rsp_valid = 1'b1; fill_rsp_address = 32'h0000_1000; fill_rsp_data = d;
    e.cyc = 32'(cyc + 1); e.way = 4'd0; e.tag = 28'h0000100; e.data = d;
    exp_q.push_back(e);
    step();
    fill_rsp_valid = 1'b0;
    step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL stall_sb: no write, want way %0d tag %h cyc %0d", e.way, e.tag, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL stall_sb: got way %0d tag %h cyc %0d data %h, want way %0d tag %h cyc %0d data %h", o.way, o.tag, o.cyc, o.data, e.way, e.tag, e.cyc, e.data); end
      end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL stall_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_mismatch_rsp();
    wr_t e, o;
    logic [127:0] d;
    do_reset();
    d = 128'hDEAD_BEEF_0000_0001_0000_0002_CAFE_F00D;
    miss_valid = 1'b1; miss_address = 32'h0000_1004;
    step();
    miss_valid = 1'b0;
    fill_req_ready = 1'b1;
    step();
    fill_req_ready = 1'b0;
    fill_rsp_valid = 1'b1; fill_rsp_address = 32'h0000_2000; fill_rsp_data = ~d;
    step();
    fill_rsp_valid = 1'b0;
    tests++; if (wr_en !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL mism_ignore: got wr_en %b busy %b want 0 1", wr_en, busy); end
    step();
    fill_rsp_valid = 1'b1; fill_rsp_address = 32'h0000_1000; fill_rsp_data = d;
    e.cyc = 32'(cyc + 1); e.way = 4'd0; e.tag = 28'h0000100; e.data = d;
    exp_q.push_back(e);
    step();
    fill_rsp_valid = 1'b0;
    step();
    tests++; if (valid_vec !== 16'h0001) begin fails++; $display("FAIL mism_valid_vec: got %h want 0001", valid_vec); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL mism_sb: no write, want way %0d tag %h cyc %0d", e.way, e.tag, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("FAIL mism_sb: got way %0d tag %h cyc %0d data %h, want way %0d tag %h cyc %0d data %h", o.way, o.tag, o.cyc, o.data, e.way, e.tag, e.cyc, e.data); end
      end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL mism_extra: got %0d extra writes want 0", obs_q.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    do_fill(32'h0000_4000, 128'h1, 0, 4'd0, 1'b0);
    tests++; if (valid_vec !== 16'h0001) begin fails++; $display("FAIL flush_pre_valid: got %h want 0001", valid_vec); end
    // flush while waiting for the response
    miss_valid = 1'b1; miss_address = 32'h0000_5000;
    step();
    miss_valid = 1'b0;
    fill_req_ready = 1'b1;
    step();
    fill_req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++; if (valid_vec !== 16'h0 || busy !== 1'b1) begin fails++; $display("FAIL flush_wait: got valid %h busy %b want 0000 1", valid_vec, busy); end
    fill_rsp_valid = 1'b1; fill_rsp_address = 32'h0000_5000; fill_rsp_data = 128'h2;
    step();
    fill_rsp_valid = 1'b0;
    tests++; if (wr_en !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL flush_drop: got wr_en %b busy %b want 0 1", wr_en, busy); end
    step();
    tests++; if (busy !== 1'b0 || valid_vec !== 16'h0) begin fails++; $display("FAIL flush_idle: got busy %b valid %h want 0 0000", busy, valid_vec); end
    // flush together with a miss in IDLE
    do_fill(32'h0000_6000, 128'h3, 0, 4'd0, 1'b0);
    flush = 1'b1; miss_valid = 1'b1; miss_address = 32'h0000_7000;
    step();
    flush = 1'b0; miss_valid = 1'b0;
    tests++; if (busy !== 1'b0 || valid_vec !== 16'h0 || fill_req_valid !== 1'b0) begin fails++; $display("FAIL flush_miss: got busy %b valid %h req %b want 0 0000 0", busy, valid_vec, fill_req_valid); end
    // flush in the write cycle
    miss_valid = 1'b1; miss_address = 32'h0000_8000;
    step();
    miss_valid = 1'b0;
    fill_req_ready = 1'b1;
    step();
    fill_req_ready = 1'b0;
    fill_rsp_valid = 1'b1; fill_rsp_address = 32'h0000_8000; fill_rsp_data = 128'h4;
    step();
    fill_rsp_valid = 1'b0;
    flush = 1'b1;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL flush_write: got wr_en %b want 0", wr_en); end
    step();
    flush = 1'b0;
    tests++; if (valid_vec !== 16'h0 || busy !== 1'b0) begin fails++; $display("FAIL flush_write_end: got valid %h busy %b want 0000 0", valid_vec, busy); end
    tests++; if (obs_q.size() != 2) begin fails++; $display("FAIL flush_wr_count: got %0d writes want 2", obs_q.size()); end
  endtask

  task automatic test_reset_in_req();
    do_reset();
    miss_valid = 1'b1; miss_address = 32'h0000_1004;
    step();
    miss_valid = 1'b0;
    tests++; if (fill_req_valid !== 1'b1) begin fails++; $display("FAIL rreq_pre: got %b want 1", fill_req_valid); end
    rst = 1'b1;
    #1;
    tests++; if (fill_req_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rreq_async: got req %b busy %b want 0 0", fill_req_valid, busy); end
    step();
    rst = 1'b0;
    fill_req_ready = 1'b1;
    step();
    fill_req_ready = 1'b0;
    fill_rsp_valid = 1'b1; fill_rsp_address = 32'h0000_1000; fill_rsp_data = 128'h5;
    step();
    fill_rsp_valid = 1'b0;
    step(); step();
    tests++; if (obs_q.size() != 0 || valid_vec !== 16'h0 || busy !== 1'b0) begin fails++; $display("FAIL rreq_late_rsp: got writes %0d valid %h busy %b want 0 0000 0", obs_q.size(), valid_vec, busy); end
  endtask

  initial begin
    rst = 1'b1;
    miss_valid = 1'b0; miss_address = '0; hit_valid = 1'b0; hit_way = '0;
    flush = 1'b0; fill_req_ready = 1'b0;
    fill_rsp_valid = 1'b0; fill_rsp_address = '0; fill_rsp_data = '0;
    step();
    test_reset();
    test_cold_miss();
    test_fill_all_ways();
    test_ready_stall();
    test_mismatch_rsp();
    test_flush();
    test_reset_in_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i_cache_fill_ctrl.md
Name: i_cache_fill_ctrl

Overview:
- Miss/fill sequencer for the 16-way fully associative instruction cache.
- Accepts a miss from the lookup stage, issues one cache-line fill request towards i_mem, and captures the response.
- Chooses the victim way (first invalid way, otherwise pseudo-LRU) and drives the single write port of the tag, valid and data arrays.
- Owns the valid vector and the PLRU tree, and handles invalidate-all (flush).

Parameters:
- WAYS_NUM, 16, number of ways (power of 2).
- CL_WIDTH, 128, cache-line width in bits.
- TAG_ADDRESS_WIDTH, 28, tag width = address[31:4].
- PLRU_BITS, 15, tree bits = WAYS_NUM-1.

Ports:
- Timing: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- miss_valid  in  1  lookup missed this cycle.
- miss_address  in  32  PC of the miss.
- hit_valid  in  1  lookup hit this cycle.
- hit_way  in  log2(WAYS_NUM)  way that hit.
- flush  in  1  invalidate all lines.
- fill_req_valid  out  1  fill request to i_mem.
- fill_req_ready  in  1  i_mem accepts the request.
- fill_req_address  out  32  line-aligned address {tag,4'b0}.
- fill_rsp_valid  in  1  fill data valid.
- fill_rsp_address  in  32  address of the returned line.
- fill_rsp_data  in  CL_WIDTH  returned line.
- wr_en  out  1  one-cycle array write strobe.
- wr_way  out  log2(WAYS_NUM)  way to write.
- wr_tag  out  TAG_ADDRESS_WIDTH  tag to write.
- wr_data  out  CL_WIDTH  line to write.
- valid_vec  out  WAYS_NUM  per-way valid bits.
- busy  out  1  fill in progress; core stalls fetch.

Behaviour:
- Reset: state=IDLE; fill_req_valid=0, fill_req_address=0, wr_en=0, wr_way=0, wr_tag=0, wr_data=0, valid_vec=0, busy=0, PLRU=0, drop flag=0.
- FSM states: IDLE, REQ, WAIT_RSP, WRITE. busy=1 in any state other than IDLE.
- IDLE, transition: on miss_valid & !flush, go to REQ.
- IDLE, captures: tag=miss_address[31:4]; victim = lowest-index way with valid_vec=0, else the PLRU victim.
- IDLE, latency: miss in cycle T gives fill_req_valid=1 at T+1.
- REQ: fill_req_valid=1 and fill_req_address={tag,4'b0}, both held stable until fill_req_ready; then go to WAIT_RSP. Valid never drops before the handshake.
- WAIT_RSP: when fill_rsp_valid and fill_rsp_address[31:4]==tag, register fill_rsp_data and go to WRITE. A response with a mismatched tag is ignored.
- WRITE: wr_en=1 for exactly one cycle with wr_way=victim, wr_tag=tag, wr_data=latched line. Same edge sets valid_vec[victim] and touches victim in the PLRU. Go to IDLE.
- Latency: response in cycle R gives wr_en at R+1 and busy=0 at R+2.
- miss_valid while busy: ignored; the lookup re-presents the miss after the refill.
- PLRU tree: node 0 is the root; children of node n are 2n+1 and 2n+2.
  - Victim walk: bit=0 goes to the lower half, bit=1 to the upper half.
  - Touch of way w: each node on w's path is set to point away from w.
  - After reset the victim is way 0.
- hit_valid touches hit_way in any state.
- Hit touch and fill touch in the same cycle: apply the hit first, then the fill; the fill wins on shared nodes.
- Flush in IDLE: valid_vec=0 and PLRU=0 at the next edge.
- Flush in REQ or WAIT_RSP: clear valid_vec and PLRU and set the drop flag. The transaction still completes (handshake done, response consumed), but WRITE suppresses wr_en and the valid update.
- Flush in WRITE: flush wins; no write and no valid bit set.
- Flush simultaneous with miss_valid in IDLE: flush is performed and the miss is ignored.
- Async reset mid-fill: immediately returns to the reset state. An outstanding i_mem response arriving afterwards is ignored because the state is IDLE.

Optional Feature:
- Macro: I_CACHE_FILL_PERF_EN.
- Defined: adds outputs perf_miss_cnt[31:0] and perf_fill_cycles[31:0].
  - perf_miss_cnt increments on each IDLE->REQ transition.
  - perf_fill_cycles increments every cycle busy=1.
  - Both are saturating, reset to 0 and cleared by flush.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss at 0x0000_1004: fill_req_address=0x0000_1000 at T+1.
  - ready at T+2, response (0x1000, data D) at T+5.
  - wr_en at T+6 with way 0, tag 0x0000100; valid_vec=0x0001; busy low at T+7.
- 16 misses to distinct lines: they fill ways 0..15 in order; valid_vec=0xFFFF.
  - A 17th miss with no hits evicts way 0 (PLRU).
  - Then hit way 0: the next victim is in the upper half (way 8).
- fill_req_ready held 0 for 5 cycles: fill_req_valid/address stay stable; no state change.
- In WAIT_RSP, a response with address 0x2000 while expecting 0x1000: ignored; a later 0x1000 response is written.
- Flush during WAIT_RSP: valid_vec=0 next cycle; the response is consumed, wr_en stays 0, and the FSM returns to IDLE.
- Reset asserted in REQ: fill_req_valid=0 and busy=0 immediately; a later response causes no write.
